// File: rtl/pipe_skid_buffer.sv
// Two-entry elastic stage: main entry feeds out_data, skid entry absorbs
// the beat that arrives while main is stalled. in_ready is a pure state decode.
module pipe_skid_buffer #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic [1:0]       count
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       state;
  logic [width-1:0] main_q;
  logic [width-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;

  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign count     = state;
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      // data regs keep stale contents; out_valid=0 hides them
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            state  <= BUSY;
            main_q <= in_data;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            state  <= FULL;
            skid_q <= in_data;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state  <= BUSY;
            main_q <= skid_q;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
